// File: rtl/ripple_carry_adder_pkg.sv
// Shared bit-level helpers for the ripple-carry adder slice.
// Keeping the full-adder equations here lets other datapath leaves reuse them.
package ripple_carry_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    function automatic logic fa_sum(input logic a, input logic b, input logic cin);
        return a ^ b ^ cin;
    endfunction

    // Generate term a&b, propagate term a^b gated by the incoming carry.
    function automatic logic fa_carry(input logic a, input logic b, input logic cin);
        return (a & b) | (cin & (a ^ b));
    endfunction

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// One-bit full adder stage; the top chains WIDTH of these through cin/cout.
module full_adder
    import ripple_carry_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = fa_sum(a, b, cin);
    assign cout = fa_carry(a, b, cin);

endmodule

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder exposing every stage carry, with an optional
// output register so intermediate carries can be tapped one cycle later.
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter bit          REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic [WIDTH-1:0] Cout
);

    // carry[i] is the carry into stage i; carry[WIDTH] is the final carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry[i]),
            .s    (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    if (REG_OUT) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                Sum  <= '0;
                Cout <= '0;
            end else begin
                Sum  <= sum_comb;
                Cout <= carry[WIDTH:1];
            end
        end
    end else begin : g_comb
        // Clock and reset have no role in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk | rst;

        assign Sum  = sum_comb;
        assign Cout = carry[WIDTH:1];
    end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Checks registered and combinational builds of the adder against an
// arithmetic reference, plus hand-computed vectors and async reset behaviour.
module tb_ripple_carry_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] sum_r, cout_r, sum_c, cout_c;
    logic [2*W-1:0] exp_reg;
    logic         chk_en = 1'b0;
    int           n_cmp  = 0;
    int           n_bad  = 0;

    always #5 clk = ~clk;

    ripple_carry_adder #(.WIDTH(W), .REG_OUT(1'b1)) dut_reg (
        .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .Sum(sum_r), .Cout(cout_r)
    );

    ripple_carry_adder #(.WIDTH(W), .REG_OUT(1'b0)) dut_comb (
        .clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .Sum(sum_c), .Cout(cout_c)
    );

    // Returns {carry vector, sum}; carry out of stage i is bit i+1 of the
    // sum of the low i+1 bits of each operand plus Cin.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic c);
        int unsigned  total;
        int unsigned  part;
        int unsigned  mask;
        logic [W-1:0] cv;
        total = int'(x) + int'(y) + int'(c);
        for (int i = 0; i < W; i++) begin
            mask  = (1 << (i + 1)) - 1;
            part  = (int'(x) & mask) + (int'(y) & mask) + int'(c);
            cv[i] = ((part >> (i + 1)) & 1) != 0;
        end
        return {cv, total[W-1:0]};
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got cout=%b sum=%b, expected cout=%b sum=%b",
                     name, act[2*W-1:W], act[W-1:0], exp[2*W-1:W], exp[W-1:0]);
        end
    endtask

    // Reference for the registered build: captures the model on each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_reg <= '0;
        else     exp_reg <= model(a, b, cin);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("reg_stream", {cout_r, sum_r}, exp_reg);
            check("comb_stream", {cout_c, sum_c}, model(a, b, cin));
        end
    end

    task automatic apply(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic [W-1:0] s_exp, input logic [W-1:0] c_exp);
        @(negedge clk);
        #2;
        a = x; b = y; cin = c;
        #1;
        check({name, "_comb"}, {cout_c, sum_c}, {c_exp, s_exp});
        @(posedge clk);
        #1;
        check({name, "_reg"}, {cout_r, sum_r}, {c_exp, s_exp});
    endtask

    initial begin
        a = '0; b = '0; cin = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_state", {cout_r, sum_r}, '0);

        // Inputs change under reset; registered outputs must hold zero.
        a = 4'hF; b = 4'hF; cin = 1'b1;
        @(posedge clk);
        #1;
        check("reset_hold", {cout_r, sum_r}, '0);
        check("comb_ignores_rst", {cout_c, sum_c}, {4'b1111, 4'b1111});

        @(negedge clk);
        #2;
        a = '0; b = '0; cin = 1'b0;
        rst = 1'b0;
        chk_en = 1'b1;

        apply("v_1_0_0", 4'h1, 4'h0, 1'b0, 4'b0001, 4'b0000);
        apply("v_2_4_1", 4'h2, 4'h4, 1'b1, 4'b0111, 4'b0000);
        apply("v_b_6_0", 4'hB, 4'h6, 1'b0, 4'b0001, 4'b1110);
        apply("v_5_3_1", 4'h5, 4'h3, 1'b1, 4'b1001, 4'b0111);
        apply("v_max",   4'hF, 4'hF, 1'b1, 4'b1111, 4'b1111);
        apply("v_zero",  4'h0, 4'h0, 1'b0, 4'b0000, 4'b0000);

        // Mid-stream asynchronous reset, asserted during the high phase.
        @(negedge clk);
        #2;
        a = 4'hF; b = 4'h1; cin = 1'b0;
        @(posedge clk);
        #2;
        check("pre_rst", {cout_r, sum_r}, {4'b1111, 4'b0000});
        rst = 1'b1;
        #1;
        check("async_rst", {cout_r, sum_r}, '0);
        @(posedge clk);
        #1;
        check("rst_hold_mid", {cout_r, sum_r}, '0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("no_capture_before_edge", {cout_r, sum_r}, '0);
        @(posedge clk);
        #1;
        check("first_capture", {cout_r, sum_r}, {4'b1111, 4'b0000});

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
